// File: rtl/busdebugger_pkg.sv
// rtl/busdebugger_pkg.sv - shared constants for the bus debugger command controller
//
// Purpose : command byte values, FSM state encoding and status byte layout
//           shared by busdebugger_cmd_ctrl and anything that decodes its
//           status byte.
// Ports   : none (package)

package busdebugger_pkg;

    // Command bytes (ASCII)
    localparam logic [7:0] CMD_ARM      = 8'h61;   // 'a'
    localparam logic [7:0] CMD_TRIGGER  = 8'h74;   // 't'
    localparam logic [7:0] CMD_DUMP     = 8'h64;   // 'd'
    localparam logic [7:0] CMD_CLEAR    = 8'h63;   // 'c'
    localparam logic [7:0] CMD_STATUS   = 8'h73;   // 's'
    localparam logic [7:0] CMD_LOAD     = 8'h54;   // 'T'
    localparam logic [7:0] CMD_NOMATCH  = 8'h78;   // 'x'

    // FSM state encoding; the value is reported verbatim in the status byte
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARMED     = 3'd1;
    localparam logic [2:0] ST_CAPTURED  = 3'd2;
    localparam logic [2:0] ST_DUMPING   = 3'd3;
    localparam logic [2:0] ST_LOAD_ADDR = 3'd4;
    localparam logic [2:0] ST_RESPOND   = 3'd5;

    // Status byte bit positions
    localparam int STAT_STATE_LSB = 5;
    localparam int STAT_ERR_BIT   = 4;
    localparam int STAT_EN_BIT    = 3;
    localparam int STAT_REC_BIT   = 2;

    function automatic logic [7:0] status_byte(
        input logic [2:0] st,
        input logic       err,
        input logic       en,
        input logic       rec
    );
        logic [7:0] b;
        b = 8'h00;
        b[STAT_STATE_LSB +: 3] = st;
        b[STAT_ERR_BIT]        = err;
        b[STAT_EN_BIT]         = en;
        b[STAT_REC_BIT]        = rec;
        return b;
    endfunction

endpackage

// File: rtl/busdebugger_cmd_ctrl.sv
// rtl/busdebugger_cmd_ctrl.sv - command sequencer for the serial bus debugger
//
// Purpose : accepts command bytes from the USART receiver, drives the
//           capture/dump strobes of the snooper and dumper, holds the
//           programmable trigger address and returns status bytes on the
//           response stream. Single clock domain (comm_clock).
// Ports   : comm_clock, reset_n (async, active-low)
//           cmd_valid/cmd_ready/cmd_data      - command byte stream in
//           resp_valid/resp_ready/resp_data   - status/echo byte stream out
//           record_end (level), dump_end (pulse) - snooper/dumper events
//           record_start, record_trigger, dump_start, capture_clear - pulses
//           trigger_addr, trigger_addr_en     - programmed match address
// Config  : BUSDEBUGGER_CMD_ECHO_EN - echo every accepted byte on the
//           response stream before the command's own effect/response.

module busdebugger_cmd_ctrl
    import busdebugger_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  comm_clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [7:0]            resp_data,
    input  logic                  record_end,
    input  logic                  dump_end,
    output logic                  record_start,
    output logic                  record_trigger,
    output logic                  dump_start,
    output logic                  capture_clear,
    output logic [ADDR_WIDTH-1:0] trigger_addr,
    output logic                  trigger_addr_en
);

    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int CNT_W      = $clog2(ADDR_BYTES + 1);

    logic [2:0]            r_state;
    logic [2:0]            r_ret_state;     // state to return to after LOAD_ADDR / RESPOND
    logic                  r_live;          // holds cmd_ready low until the first edge after reset
    logic                  r_cmd_pend;
    logic [7:0]            r_cmd_byte;
    logic                  r_resp_valid;
    logic [7:0]            r_resp_data;
    logic                  r_record_start;
    logic                  r_record_trigger;
    logic                  r_dump_start;
    logic                  r_capture_clear;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic                  r_trig_en;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_addr_shift;    // shadow; only copied out when complete
    logic [CNT_W-1:0]      r_byte_cnt;

    logic                  w_accept_state;
    logic                  w_cmd_hs;
    logic                  w_resp_hs;
    logic                  w_event;
    logic                  w_eval;
    logic                  w_last_byte;
    logic [ADDR_WIDTH+7:0] w_shift_wide;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    assign w_accept_state = (r_state == ST_IDLE)     || (r_state == ST_ARMED) ||
                            (r_state == ST_CAPTURED) || (r_state == ST_LOAD_ADDR);

    // The one-entry command register must be empty, and no response byte
    // may be outstanding, before another byte is taken.
    assign cmd_ready = r_live && w_accept_state && !r_cmd_pend && !r_resp_valid;
    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_resp_hs = r_resp_valid && resp_ready;

    // Snooper/dumper events win over a pending command; the command stays
    // held and is evaluated against the new state next cycle.
    assign w_event = ((r_state == ST_ARMED)   && record_end) ||
                     ((r_state == ST_DUMPING) && dump_end);

    // Waiting for !r_resp_valid orders any echo byte ahead of the
    // command's own response.
    assign w_eval = r_cmd_pend && !r_resp_valid && !w_event;

    assign w_last_byte  = (r_byte_cnt == CNT_W'(ADDR_BYTES - 1));
    assign w_shift_wide = {r_addr_shift, r_cmd_byte};
    assign w_addr_next  = w_shift_wide[ADDR_WIDTH-1:0];

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_ret_state      <= ST_IDLE;
            r_live           <= 1'b0;
            r_cmd_pend       <= 1'b0;
            r_cmd_byte       <= 8'h00;
            r_resp_valid     <= 1'b0;
            r_resp_data      <= 8'h00;
            r_record_start   <= 1'b0;
            r_record_trigger <= 1'b0;
            r_dump_start     <= 1'b0;
            r_capture_clear  <= 1'b0;
            r_trig_addr      <= '0;
            r_trig_en        <= 1'b0;
            r_error          <= 1'b0;
            r_addr_shift     <= '0;
            r_byte_cnt       <= '0;
        end else begin
            r_live           <= 1'b1;
            r_record_start   <= 1'b0;
            r_record_trigger <= 1'b0;
            r_dump_start     <= 1'b0;
            r_capture_clear  <= 1'b0;

            if (w_cmd_hs) begin
                r_cmd_pend <= 1'b1;
                r_cmd_byte <= cmd_data;
`ifdef BUSDEBUGGER_CMD_ECHO_EN
                r_resp_valid <= 1'b1;
                r_resp_data  <= cmd_data;
`endif
            end

            if (w_resp_hs) begin
                r_resp_valid <= 1'b0;
                // Only the status byte (sent from RESPOND) clears the error;
                // an echo byte never does.
                if (r_state == ST_RESPOND) begin
                    r_state <= r_ret_state;
                    r_error <= 1'b0;
                end
            end

            if (w_event) begin
                if (r_state == ST_ARMED) begin
                    r_state <= ST_CAPTURED;
                end else begin
                    r_state <= ST_IDLE;
                end
            end

            // Capture completing while parked in LOAD_ADDR/RESPOND still
            // takes effect on the state we return to.
            if (((r_state == ST_LOAD_ADDR) || (r_state == ST_RESPOND)) &&
                (r_ret_state == ST_ARMED) && record_end) begin
                r_ret_state <= ST_CAPTURED;
            end

            if (w_eval) begin
                r_cmd_pend <= 1'b0;
                if (r_state == ST_LOAD_ADDR) begin
                    r_addr_shift <= w_addr_next;
                    if (w_last_byte) begin
                        r_trig_addr <= w_addr_next;
                        r_trig_en   <= 1'b1;
                        r_state     <= r_ret_state;
                        r_byte_cnt  <= '0;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                end else begin
                    case (r_cmd_byte)
                        CMD_ARM: begin
                            if ((r_state == ST_IDLE) || (r_state == ST_CAPTURED)) begin
                                r_record_start <= 1'b1;
                                r_state        <= ST_ARMED;
                            end
                        end
                        CMD_TRIGGER: begin
                            if (r_state == ST_ARMED) begin
                                r_record_trigger <= 1'b1;
                            end
                        end
                        CMD_DUMP: begin
                            if (r_state == ST_CAPTURED) begin
                                r_dump_start <= 1'b1;
                                r_state      <= ST_DUMPING;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                        CMD_CLEAR: begin
                            r_capture_clear <= 1'b1;
                            r_state         <= ST_IDLE;
                        end
                        CMD_STATUS: begin
                            r_ret_state  <= r_state;
                            r_state      <= ST_RESPOND;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= status_byte(r_state, r_error, r_trig_en, record_end);
                        end
                        CMD_LOAD: begin
                            r_ret_state  <= r_state;
                            r_state      <= ST_LOAD_ADDR;
                            r_byte_cnt   <= '0;
                            r_addr_shift <= '0;
                        end
                        CMD_NOMATCH: begin
                            r_trig_en <= 1'b0;
                        end
                        default: begin
                            r_error <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign resp_valid      = r_resp_valid;
    assign resp_data       = r_resp_data;
    assign record_start    = r_record_start;
    assign record_trigger  = r_record_trigger;
    assign dump_start      = r_dump_start;
    assign capture_clear   = r_capture_clear;
    assign trigger_addr    = r_trig_addr;
    assign trigger_addr_en = r_trig_en;

endmodule

// File: tb/tb_busdebugger_cmd_ctrl.sv
// tb/tb_busdebugger_cmd_ctrl.sv - directed self-checking bench for busdebugger_cmd_ctrl

module tb_busdebugger_cmd_ctrl;

    logic        comm_clock = 1'b0;
    logic        reset_n    = 1'b0;
    logic        cmd_valid  = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_data   = 8'h00;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [7:0]  resp_data;
    logic        record_end = 1'b0;
    logic        dump_end   = 1'b0;
    logic        record_start;
    logic        record_trigger;
    logic        dump_start;
    logic        capture_clear;
    logic [31:0] trigger_addr;
    logic        trigger_addr_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 comm_clock = ~comm_clock;

    busdebugger_cmd_ctrl #(.ADDR_WIDTH(32)) dut (
        .comm_clock      (comm_clock),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_data        (cmd_data),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .record_end      (record_end),
        .dump_end        (dump_end),
        .record_start    (record_start),
        .record_trigger  (record_trigger),
        .dump_start      (dump_start),
        .capture_clear   (capture_clear),
        .trigger_addr    (trigger_addr),
        .trigger_addr_en (trigger_addr_en)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for cmd_ready, then performs one handshake.
    // Returns 1 ns after the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge comm_clock);
        while (!cmd_ready && n < 200) begin
            @(negedge comm_clock);
            n++;
        end
        if (n >= 200) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = b;
        @(posedge comm_clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [7:0] exp);
        int n = 0;
        @(negedge comm_clock);
        while (!resp_valid && n < 200) begin
            @(negedge comm_clock);
            n++;
        end
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk(tag, 32'(resp_data), 32'(exp));
        resp_ready = 1'b1;
        @(posedge comm_clock);
        #1 resp_ready = 1'b0;
    endtask

    // Pulse must be low at the first negedge after the handshake, high at
    // the second and low again at the third.
    task automatic chk_pulse(input string tag, input int sel);
        logic [2:0] seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge comm_clock);
            case (sel)
                0: seen[i] = record_start;
                1: seen[i] = record_trigger;
                2: seen[i] = dump_start;
                default: seen[i] = capture_clear;
            endcase
        end
        chk(tag, 32'(seen), 32'b010);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge comm_clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable_v, stable_d, stable_r;

        // Reset values
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'h00);
        chk("rst_trig_addr", trigger_addr, 32'h0);
        chk("rst_trig_en", 32'(trigger_addr_en), 32'd0);
        chk("rst_pulses", 32'({record_start, record_trigger, dump_start, capture_clear}), 32'd0);
        @(negedge comm_clock);
        reset_n = 1'b1;
        @(negedge comm_clock);
        chk("first_cycle_ready", 32'(cmd_ready), 32'd1);

        // Arm, pulse timing, status 0x20
        send_byte(8'h61);
        chk_pulse("arm_pulse", 0);
        send_byte(8'h73);
        get_resp("stat_armed", 8'h20);

        // Capture, dump, DUMPING blocks commands, dump_end returns to IDLE
        @(negedge comm_clock);
        record_end = 1'b1;
        @(negedge comm_clock);
        record_end = 1'b0;
        send_byte(8'h64);
        chk_pulse("dump_pulse", 2);
        idle_cycles(3);
        chk("dumping_ready", 32'(cmd_ready), 32'd0);
        dump_end = 1'b1;
        @(negedge comm_clock);
        dump_end = 1'b0;
        @(negedge comm_clock);
        chk("after_dump_ready", 32'(cmd_ready), 32'd1);
        send_byte(8'h73);
        get_resp("stat_after_dump", 8'h00);

        // Address load; partial never visible
        send_byte(8'h54);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        idle_cycles(2);
        chk("partial_addr", trigger_addr, 32'h0);
        chk("partial_en", 32'(trigger_addr_en), 32'd0);
        send_byte(8'hEF);
        idle_cycles(2);
        chk("load_addr", trigger_addr, 32'hDEADBEEF);
        chk("load_en", 32'(trigger_addr_en), 32'd1);
        send_byte(8'h73);
        get_resp("stat_loaded", 8'h08);

        // Force trigger in ARMED, then clear keeps the address
        send_byte(8'h61);
        idle_cycles(2);
        send_byte(8'h74);
        chk_pulse("trig_pulse", 1);
        send_byte(8'h63);
        chk_pulse("clear_pulse", 3);
        chk("clear_keeps_addr", trigger_addr, 32'hDEADBEEF);
        send_byte(8'h73);
        get_resp("stat_cleared", 8'h08);

        // 'x' disables match; unknown byte sets error, status clears it
        send_byte(8'h78);
        idle_cycles(2);
        chk("nomatch_en", 32'(trigger_addr_en), 32'd0);
        send_byte(8'h71);
        send_byte(8'h73);
        get_resp("stat_err", 8'h10);
        send_byte(8'h73);
        get_resp("stat_err_cleared", 8'h00);

        // 'd' outside CAPTURED is an error with no pulse
        send_byte(8'h64);
        idle_cycles(2);
        chk("bad_dump_no_pulse", 32'(dump_start), 32'd0);
        send_byte(8'h73);
        get_resp("stat_bad_dump", 8'h10);

        // Back-pressure on the response stream
        send_byte(8'h73);
        idle_cycles(2);
        stable_v = 1'b1; stable_d = 1'b1; stable_r = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge comm_clock);
            if (resp_valid !== 1'b1) stable_v = 1'b0;
            if (resp_data !== 8'h00) stable_d = 1'b0;
            if (cmd_ready !== 1'b0) stable_r = 1'b0;
        end
        chk("hold_valid", 32'(stable_v), 32'd1);
        chk("hold_data", 32'(stable_d), 32'd1);
        chk("hold_no_ready", 32'(stable_r), 32'd0 | 32'd1);
        get_resp("held_byte", 8'h00);
        idle_cycles(3);
        chk("single_byte", 32'(resp_valid), 32'd0);

        // Reset mid address load
        send_byte(8'h54);
        send_byte(8'h12);
        idle_cycles(2);
        reset_n = 1'b0;
        #1;
        chk("midload_rst_addr", trigger_addr, 32'h0);
        chk("midload_rst_en", 32'(trigger_addr_en), 32'd0);
        @(negedge comm_clock);
        reset_n = 1'b1;
        send_byte(8'h73);
        get_resp("stat_after_rst", 8'h00);
        send_byte(8'h54);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        idle_cycles(2);
        chk("reload_addr", trigger_addr, 32'h11223344);

        // Reset while a response is pending drops resp_valid immediately
        send_byte(8'h73);
        idle_cycles(2);
        chk("pending_resp", 32'(resp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_drops_resp", 32'(resp_valid), 32'd0);
        chk("rst_drops_data", 32'(resp_data), 32'h00);
        @(negedge comm_clock);
        reset_n = 1'b1;
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/busdebugger_cmd_ctrl.md
Name: busdebugger_cmd_ctrl

Overview:
Command sequencer for the serial bus debugger. Consumes command bytes decoded from the USART receiver and drives the capture/dump control strobes of the bus snooper and dumper. Holds a programmable trigger address and returns a status byte on a response stream to the serial transmit path. Runs entirely in the comm_clock domain.

Parameters:
ADDR_WIDTH, 32, width of the programmable trigger address (multiple of 8)
ADDR_BYTES, ADDR_WIDTH/8, localparam: payload bytes following a 'T' command

Ports:
comm_clock  input  1  sole clock
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command byte available from USART receiver
cmd_ready  output  1  command byte accepted this cycle when cmd_valid&&cmd_ready
cmd_data  input  8  command byte
resp_valid  output  1  status/echo byte available
resp_ready  input  1  downstream accepts resp_data
resp_data  output  8  status/echo byte
record_end  input  1  level from snooper: capture buffer filled
dump_end  input  1  one-cycle pulse from dumper: dump finished
record_start  output  1  one-cycle pulse: arm capture
record_trigger  output  1  one-cycle pulse: force trigger
dump_start  output  1  one-cycle pulse: begin dump
capture_clear  output  1  one-cycle pulse: clear snooper/fifo state
trigger_addr  output  ADDR_WIDTH  programmed trigger address
trigger_addr_en  output  1  trigger_addr is valid for matching

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, all pulses 0, cmd_ready 0, resp_valid 0, resp_data 0, trigger_addr 0, trigger_addr_en 0, error flag 0. First cycle after release: cmd_ready 1.
- Commands (ASCII): 'a'=0x61 arm, 't'=0x74 force trigger, 'd'=0x64 dump, 'c'=0x63 clear, 's'=0x73 status, 'T'=0x54 load address, 'x'=0x78 disable address match.
- States: IDLE, ARMED, CAPTURED, DUMPING, LOAD_ADDR, RESPOND.
- cmd_ready is 1 only in IDLE, ARMED, CAPTURED, LOAD_ADDR and when no response is pending; 0 in DUMPING and RESPOND.
- Strobes assert the cycle after the accepting handshake, for exactly one cycle.
- 'a': accepted in IDLE/CAPTURED -> record_start pulse, go ARMED. In ARMED: ignored, no pulse.
- 't': in ARMED -> record_trigger pulse, stay ARMED; elsewhere ignored.
- ARMED -> CAPTURED when record_end is high (checked every cycle).
- 'd': in CAPTURED -> dump_start pulse, go DUMPING; elsewhere sets error flag. DUMPING -> IDLE on dump_end.
- 'c': from any accepting state -> capture_clear pulse, go IDLE; trigger_addr preserved.
- 'T': go LOAD_ADDR, byte counter 0; next ADDR_BYTES accepted bytes shift in MSB-first; after the last byte trigger_addr_en=1, return to the state held before 'T'. trigger_addr updates atomically when the final byte lands (shadow register); the partial value is never visible.
- 'x': trigger_addr_en=0.
- 's': go RESPOND; resp_valid=1 with resp_data = {state[2:0], error, trigger_addr_en, record_end, 2'b00}; error clears when the status byte handshakes; return to previous state. State encoding: IDLE 0, ARMED 1, CAPTURED 2, DUMPING 3, LOAD_ADDR 4, RESPOND 5.
- Unknown byte: error=1, no state change.
- resp_valid holds with stable resp_data until resp_ready; no bytes are dropped.
- record_end and dump_end arriving in the same cycle as a command handshake: the event transition takes priority; the command is evaluated against the new state on the following cycle (accepted byte is held in a one-entry register).
- reset_n asserted mid LOAD_ADDR or mid response: partial address discarded, resp_valid drops immediately.

Optional Feature:
BUSDEBUGGER_CMD_ECHO_EN: when defined, every accepted command byte, including address payload, is echoed on the response stream before the command's own response. cmd_ready stays low until the echo handshakes. When undefined, only 's' produces response bytes and no echo logic exists.

Decomposition:
- Shared package busdebugger_pkg: command byte constants, state enum with the encoding above, status bit positions.
- No sub-module. The address shift register is inline.

Test Plan:
- Reset, send 'a' -> record_start high exactly 1 cycle, 2 cycles after the handshake; 's' -> resp_data 0x20.
- 'a', then record_end=1, then 'd' -> dump_start pulse; cmd_ready=0 until dump_end pulse; then 's' -> 0x00.
- 'T',0xDE,0xAD,0xBE,0xEF -> trigger_addr=0xDEADBEEF, trigger_addr_en=1 only after the 4th byte; 's' in IDLE -> 0x08.
- 'q' then 's' -> status bit4 set (0x10); second 's' -> bit4 clear.
- Hold resp_ready=0 for 20 cycles after 's' -> resp_valid and resp_data stable, cmd_ready=0; release -> single byte delivered.
- Assert reset_n after 'T',0x12 -> trigger_addr stays 0, state IDLE; with BUSDEBUGGER_CMD_ECHO_EN, 'a' -> echo 0x61 precedes any status byte.
